tx_dac_pr: RTL
==============

// Module: tx_dac_pr
// PURPOSE
//  Emulation model of the TX DAC slice; drives the channel input that the RX ADC slice samples.
//  - Accepts sign/magnitude symbols, the same format the ADC emits.
//  - Paces consumption from an emulated clock divided by 2^Ndiv.
//  - Converts each symbol to a signed PWL fixed-point level.
//  - Requests emulator timesteps.
// PARAMETERS
//  Ndiv       2    divider width; one symbol per 2^Ndiv clk_tx negedges
//  Nadc       8    magnitude width of din_mag
//  PWL_W      18   width of vout (signed fixed point, PWL format)
//  GAIN_SHIFT 4    LSB scaling: vout = signed_code <<< GAIN_SHIFT
//  DT_W       18   width of dt_req / emu_dt
//  SLEW_STEP  8    per-cycle vout step (slew build only)
// PORTS
//  emu_clk      in   1       emulator clock
//  rstb         in   1       async active-low reset
//  clk_tx       in   1       emulated TX clock (level sampled on emu_clk)
//  en_tx        in   1       slice enable
//  en_sync_in   in   1       divider sync enable
//  init         in   Ndiv    divider preload
//  din_sgn      in   1       symbol sign (1 = negative)
//  din_mag      in   Nadc    symbol magnitude
//  din_valid    in   1       symbol available
//  din_ready    out  1       one-cycle pulse: symbol consumed
//  vout         out  PWL_W   signed analog level
//  dt_req       out  DT_W    requested timestep
//  emu_dt       in   DT_W    granted timestep (unused unless slew build)
//  underrun     out  1       sticky: strobe with din_valid low
//  sym_cnt      out  16      symbols consumed, wraps at 0xFFFF -> 0
// BEHAVIOUR
//  Reset values: all state cleared; vout=0, din_ready=0, underrun=0, sym_cnt=0, state OFF, dt_req=max.
//  Edge detection: clk_prev<=clk_tx each emu_clk; negedge = ~clk_tx & clk_prev.
//  FSM:
//  - OFF: count<=init; leave when en_tx=1 -> ARMED.
//  - ARMED: en_sync_in sampled on negedge; when sampled value is 1 -> RUN.
//  - RUN: count increments on each negedge; en_tx=0 or en_sync_in=0 at negedge -> OFF (vout holds).
//  Strobe: in RUN, strobe = negedge & (count == all-ones), i.e. the wrap edge.
//  On strobe at cycle N:
//  - din_valid=1: capture symbol, din_ready=1 at N, sym_cnt++.
//  - din_valid=0: hold previous symbol, set underrun, no din_ready.
//  - vout updates at N+1, so latency is 1 emu_clk.
//  Code: signed_code = din_sgn ? -mag : +mag (Nadc+1 bits); negative zero -> 0.
//  Scaling: vout = sign-extended code <<< GAIN_SHIFT; no saturation needed (Nadc+1+GAIN_SHIFT <= PWL_W).
//  dt_req = {1'b0,{DT_W-1{1'b1}}} (max) except while ramping in the slew build.
//  Simultaneous: strobe with en_tx falling -> symbol still consumed, then OFF.
//  Reset mid-RUN: immediate clear, including vout and sym_cnt.
//  underrun clears only on reset.
// CONFIGURATION
//  TX_DAC_SLEW_EN defined:
//  - vout is a ramp register; each emu_clk with emu_dt!=0 it moves toward target by SLEW_STEP.
//  - Snaps to target when |target-vout| <= SLEW_STEP.
//  - dt_req = 1 while |target-vout| > 0.
//  TX_DAC_SLEW_EN undefined: vout = target directly; emu_dt ignored.
// STRUCTURE
//  Package tx_dac_pkg: state enum {OFF,ARMED,RUN}, DT_MAX constant, signed-code typedef.
//  Sub-module emu_edge_det: prev register plus posedge/negedge outputs; reusable by ADC models.
// TESTING
//  T1 Ndiv=2, init=0, continuous valid, mag=5 sgn=0:
//     strobe on every 4th negedge; vout=80 one cycle after; din_ready 1-cycle pulses.
//  T2 sgn=1 mag=5 -> vout=-80; sgn=1 mag=0 -> vout=0.
//  T3 din_valid low at a strobe -> underrun=1, vout holds, sym_cnt unchanged;
//     next valid symbol resumes normally.
//  T4 init=3 -> first strobe on first RUN negedge; init=0 -> fourth negedge.
//  T5 rstb low mid-RUN with vout=-80 -> vout=0, sym_cnt=0, state OFF;
//     en_sync_in must re-arm before the next strobe.
//  T6 (TX_DAC_SLEW_EN) 0 -> 80 with SLEW_STEP=8, emu_dt=1 -> 10 cycles of +8, dt_req=1 during ramp, max after.

Source files
------------

// File: rtl/tx_dac_pkg.sv
// Shared types and constants for the TX DAC emulation slice.
// Reused by the ADC-side models that share the sign/magnitude symbol format.
package tx_dac_pkg;

  typedef enum logic [1:0] {OFF, ARMED, RUN} tx_state_t;

  localparam int DEF_NADC = 8;
  localparam int DEF_DT_W = 18;

  // Largest positive timestep; asking for it lets the emulator run freely.
  localparam logic [DEF_DT_W-1:0] DT_MAX = {1'b0, {(DEF_DT_W-1){1'b1}}};

  typedef logic signed [DEF_NADC:0] sym_code_t;

endpackage

// File: rtl/emu_edge_det.sv
// Level-sampled edge detector for emulated clocks.
// It registers the previous level on emu_clk and flags rising and falling edges.
module emu_edge_det (
  input  logic emu_clk,
  input  logic rstb,
  input  logic sig,
  output logic pos_edge,
  output logic neg_edge
);

  logic sig_prev;

  // The previous level resets low, so a high input after reset does not fake a falling edge.
  always_ff @(posedge emu_clk or negedge rstb) begin
    if (!rstb) sig_prev <= 1'b0;
    else       sig_prev <= sig;
  end

  assign pos_edge = sig & ~sig_prev;
  assign neg_edge = ~sig & sig_prev;

endmodule

// File: rtl/tx_dac_pr.sv
// TX DAC emulation slice: paced sign/magnitude symbols -> signed PWL level.
// Define TX_DAC_SLEW_EN to get a slew-limited vout that requests small timesteps while ramping.
module tx_dac_pr
  import tx_dac_pkg::*;
#(
  parameter int Ndiv       = 2,
  parameter int Nadc       = DEF_NADC,
  parameter int PWL_W      = 18,
  parameter int GAIN_SHIFT = 4,
  parameter int DT_W       = DEF_DT_W,
  parameter int SLEW_STEP  = 8
) (
  input  logic              emu_clk,
  input  logic              rstb,
  input  logic              clk_tx,
  input  logic              en_tx,
  input  logic              en_sync_in,
  input  logic [Ndiv-1:0]   init,
  input  logic              din_sgn,
  input  logic [Nadc-1:0]   din_mag,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [PWL_W-1:0]  vout,
  output logic [DT_W-1:0]   dt_req,
  input  logic [DT_W-1:0]   emu_dt,
  output logic              underrun,
  output logic [15:0]       sym_cnt
);

  localparam logic [DT_W-1:0] DT_REQ_MAX = {1'b0, {(DT_W-1){1'b1}}};

  tx_state_t state, state_nxt;
  logic [Ndiv-1:0] count;
  logic tx_neg, unused_pos;
  logic strobe;
  logic signed [Nadc:0] code;
  logic signed [PWL_W-1:0] level, target;

  emu_edge_det u_edge (
    .emu_clk  (emu_clk),
    .rstb     (rstb),
    .sig      (clk_tx),
    .pos_edge (unused_pos),
    .neg_edge (tx_neg)
  );

  always_ff @(posedge emu_clk or negedge rstb) begin
    if (!rstb) state <= OFF;
    else       state <= state_nxt;
  end

  // Leaving RUN is only evaluated on a clk_tx falling edge, so a strobe on that edge still lands.
  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:     if (en_tx) state_nxt = ARMED;
      ARMED: begin
        if (!en_tx)                   state_nxt = OFF;
        else if (tx_neg && en_sync_in) state_nxt = RUN;
      end
      RUN:     if (tx_neg && (!en_tx || !en_sync_in)) state_nxt = OFF;
      default: state_nxt = OFF;
    endcase
  end

  always_comb begin
    strobe    = (state == RUN) && tx_neg && (&count);
    din_ready = strobe && din_valid;
  end

  always_ff @(posedge emu_clk or negedge rstb) begin
    if (!rstb)                         count <= '0;
    else if (state == OFF)             count <= init;
    else if (state == RUN && tx_neg)   count <= count + 1'b1;
  end

  // Negating the zero-extended magnitude maps the "negative zero" symbol onto 0.
  assign code  = din_sgn ? -$signed({1'b0, din_mag}) : $signed({1'b0, din_mag});
  assign level = $signed({{(PWL_W-Nadc-1){code[Nadc]}}, code}) <<< GAIN_SHIFT;

  always_ff @(posedge emu_clk or negedge rstb) begin
    if (!rstb) begin
      target   <= '0;
      sym_cnt  <= '0;
      underrun <= 1'b0;
    end else if (strobe) begin
      if (din_valid) begin
        target  <= level;
        sym_cnt <= sym_cnt + 16'd1;
      end else begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef TX_DAC_SLEW_EN
  localparam logic signed [PWL_W:0] STEP = (PWL_W+1)'(SLEW_STEP);
  logic signed [PWL_W-1:0] ramp;
  logic signed [PWL_W:0] diff;

  assign diff = {target[PWL_W-1], target} - {ramp[PWL_W-1], ramp};

  // The ramp advances only on granted timesteps and snaps once within one step.
  always_ff @(posedge emu_clk or negedge rstb) begin
    if (!rstb) begin
      ramp <= '0;
    end else if (emu_dt != '0) begin
      if (diff <= STEP && diff >= -STEP) ramp <= target;
      else if (diff > 0)                 ramp <= ramp + PWL_W'(SLEW_STEP);
      else                               ramp <= ramp - PWL_W'(SLEW_STEP);
    end
  end

  assign vout   = ramp;
  assign dt_req = (diff != '0) ? DT_W'(1) : DT_REQ_MAX;
`else
  logic unused_dt;
  localparam int unused_slew = SLEW_STEP;

  assign unused_dt = ^emu_dt;
  assign vout      = target;
  assign dt_req    = DT_REQ_MAX;
`endif

endmodule
